// File: rtl/riscv_zero_imem_loader.sv
// Boot/reload sequencer for the instruction RAM: streams host words into RAM while the
// core is held in reset, then releases the core and hands the RAM address to fetch.
module riscv_zero_imem_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_start,
    input  logic             run_req,
    input  logic             ld_valid,
    input  logic [31:0]      ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    input  logic [31:0]      fetch_pc,
    output logic             mem_write_enable,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_data_in,
    output logic             core_reset,
    output logic [CNT_W-1:0] load_count,
    output logic             load_full
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DEPTH_WORDS - 1);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             full_reg, full_next;
    logic             we_reg, we_next;
    logic [31:0]      addr_reg, addr_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic             accept;

    // A restart request masks ready so a word offered in the same cycle is dropped.
    assign ld_ready = (state_reg == ST_LOAD) && (count_reg < DEPTH_CNT) && !ld_start;
    assign accept   = ld_valid && ld_ready;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        full_next  = full_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ld_start) begin
                    state_next = ST_LOAD;
                    count_next = '0;
                    full_next  = 1'b0;
                end else if (run_req) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_LOAD: begin
                if (ld_start) begin
                    count_next = '0;
                    full_next  = 1'b0;
                end else if (accept) begin
                    we_next    = 1'b1;
                    addr_next  = BASE_ADDR + (32'(count_reg) << 2);
                    wdata_next = ld_data;
                    count_next = count_reg + 1'b1;
                    if (ld_last) begin
                        state_next = ST_SETTLE;
                    end else if (count_reg == LAST_IDX) begin
                        full_next  = 1'b1;
                        state_next = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                // The final registered write is presented to RAM during this cycle.
                addr_next  = BASE_ADDR;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (ld_start) begin
                    state_next = ST_LOAD;
                    count_next = '0;
                    full_next  = 1'b0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            full_reg  <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= BASE_ADDR;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            full_reg  <= full_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    // Fetch owns the address in RUN with no extra latency.
    assign mem_address      = (state_reg == ST_RUN) ? fetch_pc : addr_reg;
    assign mem_write_enable = we_reg;
    assign mem_data_in      = wdata_reg;
    assign core_reset       = (state_reg != ST_RUN);
    assign load_count       = count_reg;
    assign load_full        = full_reg;

endmodule

// File: tb/tb_riscv_zero_imem_loader.sv
// Directed bench for riscv_zero_imem_loader: default-depth instance plus a 4-word
// instance for the overflow case, each backed by a bench-owned RAM.
module tb_riscv_zero_imem_loader;

    logic        clk = 1'b0;
    logic        reset, ld_start, run_req, ld_valid, ld_last;
    logic [31:0] ld_data, fetch_pc;

    logic        ld_ready_b, we_b, core_reset_b, full_b;
    logic [31:0] addr_b, din_b;
    logic [8:0]  count_b;

    logic        ld_ready_s, we_s, core_reset_s, full_s;
    logic [31:0] addr_s, din_s;
    logic [2:0]  count_s;

    logic [31:0] ram_b [0:255];
    logic [31:0] ram_s [0:255];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    riscv_zero_imem_loader dut_b (
        .clk(clk), .reset(reset), .ld_start(ld_start), .run_req(run_req),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready_b),
        .fetch_pc(fetch_pc), .mem_write_enable(we_b), .mem_address(addr_b),
        .mem_data_in(din_b), .core_reset(core_reset_b), .load_count(count_b),
        .load_full(full_b)
    );

    riscv_zero_imem_loader #(.DEPTH_WORDS(4)) dut_s (
        .clk(clk), .reset(reset), .ld_start(ld_start), .run_req(run_req),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready_s),
        .fetch_pc(fetch_pc), .mem_write_enable(we_s), .mem_address(addr_s),
        .mem_data_in(din_s), .core_reset(core_reset_s), .load_count(count_s),
        .load_full(full_s)
    );

    always @(posedge clk) begin
        if (we_b) begin
            ram_b[addr_b[9:2]] <= din_b;
            $display("[TB] ram_b write addr=%08h data=%08h", addr_b, din_b);
        end
        if (we_s) begin
            ram_s[addr_s[9:2]] <= din_s;
            $display("[TB] ram_s write addr=%08h data=%08h", addr_s, din_s);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_start = 1'b0; run_req = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        fetch_pc = 32'h0000_0F00;
        do_reset();
        #1;
        tests_run++; if (core_reset_b !== 1'b1) begin tests_failed++; $display("FAIL reset_core_reset got %0b exp 1", core_reset_b); end
        tests_run++; if (ld_ready_b !== 1'b0) begin tests_failed++; $display("FAIL reset_ld_ready got %0b exp 0", ld_ready_b); end
        tests_run++; if (we_b !== 1'b0) begin tests_failed++; $display("FAIL reset_we got %0b exp 0", we_b); end
        tests_run++; if (addr_b !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got %08h exp 00000000", addr_b); end
        tests_run++; if (count_b !== 9'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", count_b); end
        tests_run++; if (din_b !== 32'h0) begin tests_failed++; $display("FAIL reset_data got %08h exp 0", din_b); end
        tests_run++; if (full_b !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %0b exp 0", full_b); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        words = '{32'hABCD1234, 32'hABCD5678, 32'h08080808};
        do_reset();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 2);
            #1;
            tests_run++; if (ld_ready_b !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready[%0d] got %0b exp 1", i, ld_ready_b); end
            tick();
            tests_run++; if (we_b !== 1'b1) begin tests_failed++; $display("FAIL b2b_we[%0d] got %0b exp 1", i, we_b); end
            tests_run++; if (addr_b !== 32'(4 * i)) begin tests_failed++; $display("FAIL b2b_addr[%0d] got %08h exp %08h", i, addr_b, 32'(4 * i)); end
            tests_run++; if (din_b !== words[i]) begin tests_failed++; $display("FAIL b2b_data[%0d] got %08h exp %08h", i, din_b, words[i]); end
            tests_run++; if (count_b !== 9'(i + 1)) begin tests_failed++; $display("FAIL b2b_count[%0d] got %0d exp %0d", i, count_b, i + 1); end
        end
        idle_inputs();
        #1;
        tests_run++; if (core_reset_b !== 1'b1) begin tests_failed++; $display("FAIL b2b_settle_core_reset got %0b exp 1", core_reset_b); end
        tests_run++; if (ld_ready_b !== 1'b0) begin tests_failed++; $display("FAIL b2b_settle_ready got %0b exp 0", ld_ready_b); end
        tick();
        tests_run++; if (core_reset_b !== 1'b0) begin tests_failed++; $display("FAIL b2b_run_core_reset got %0b exp 0", core_reset_b); end
        tests_run++; if (we_b !== 1'b0) begin tests_failed++; $display("FAIL b2b_run_we got %0b exp 0", we_b); end
        fetch_pc = 32'h0000_001C;
        #1;
        tests_run++; if (addr_b !== 32'h0000_001C) begin tests_failed++; $display("FAIL b2b_fetch_addr got %08h exp 0000001c", addr_b); end
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (ram_b[i] !== words[i]) begin tests_failed++; $display("FAIL b2b_ram[%0d] got %08h exp %08h", i, ram_b[i], words[i]); end
        end
        fetch_pc = 32'h0000_0F00;
    endtask

    task automatic test_bubbles();
        logic [31:0] words [3];
        int gaps [3];
        words = '{32'h11111111, 32'h22222222, 32'h33333333};
        gaps  = '{1, 2, 0};
        do_reset();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 2);
            tick();
            tests_run++; if (we_b !== 1'b1 || addr_b !== 32'(4 * i)) begin tests_failed++; $display("FAIL bub_write[%0d] got we=%0b addr=%08h exp we=1 addr=%08h", i, we_b, addr_b, 32'(4 * i)); end
            for (int g = 0; g < gaps[i]; g++) begin
                idle_inputs();
                tick();
                tests_run++; if (we_b !== 1'b0 || addr_b !== 32'(4 * i)) begin tests_failed++; $display("FAIL bub_gap[%0d.%0d] got we=%0b addr=%08h exp we=0 addr=%08h", i, g, we_b, addr_b, 32'(4 * i)); end
            end
        end
        idle_inputs();
        tick();
        tests_run++; if (core_reset_b !== 1'b0 || count_b !== 9'd3) begin tests_failed++; $display("FAIL bub_run got core_reset=%0b count=%0d exp 0/3", core_reset_b, count_b); end
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (ram_b[i] !== words[i]) begin tests_failed++; $display("FAIL bub_ram[%0d] got %08h exp %08h", i, ram_b[i], words[i]); end
        end
    endtask

    task automatic test_full();
        do_reset();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1; ld_data = 32'h5000_0000 + 32'(i); ld_last = 1'b0;
            #1;
            tests_run++; if (ld_ready_s !== (i < 4)) begin tests_failed++; $display("FAIL full_ready[%0d] got %0b exp %0b", i, ld_ready_s, (i < 4)); end
            tick();
            if (i < 4) begin
                tests_run++; if (we_s !== 1'b1 || addr_s !== 32'(4 * i)) begin tests_failed++; $display("FAIL full_write[%0d] got we=%0b addr=%08h exp we=1 addr=%08h", i, we_s, addr_s, 32'(4 * i)); end
            end else begin
                tests_run++; if (we_s !== 1'b0) begin tests_failed++; $display("FAIL full_no_fifth_write got we=%0b exp 0", we_s); end
            end
            if (i == 3) begin
                tests_run++; if (full_s !== 1'b1 || count_s !== 3'd4 || core_reset_s !== 1'b1) begin tests_failed++; $display("FAIL full_settle got full=%0b count=%0d core_reset=%0b exp 1/4/1", full_s, count_s, core_reset_s); end
            end
        end
        idle_inputs();
        tests_run++; if (core_reset_s !== 1'b0 || full_s !== 1'b1 || count_s !== 3'd4) begin tests_failed++; $display("FAIL full_run got core_reset=%0b full=%0b count=%0d exp 0/1/4", core_reset_s, full_s, count_s); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (ram_s[i] !== 32'h5000_0000 + 32'(i)) begin tests_failed++; $display("FAIL full_ram[%0d] got %08h exp %08h", i, ram_s[i], 32'h5000_0000 + 32'(i)); end
        end
    endtask

    task automatic test_reload();
        do_reset();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'hAAAA0001; ld_last = 1'b0;
        tick();
        ld_data = 32'hAAAA0002; ld_last = 1'b1;
        tick();
        idle_inputs();
        tick();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        tests_run++; if (core_reset_b !== 1'b0) begin tests_failed++; $display("FAIL reload_run_req_ignored got core_reset=%0b exp 0", core_reset_b); end
        ld_start = 1'b1;
        #1;
        tests_run++; if (core_reset_b !== 1'b0 || ld_ready_b !== 1'b0) begin tests_failed++; $display("FAIL reload_start_cycle got core_reset=%0b ready=%0b exp 0/0", core_reset_b, ld_ready_b); end
        tick();
        ld_start = 1'b0;
        tests_run++; if (core_reset_b !== 1'b1 || count_b !== 9'd0) begin tests_failed++; $display("FAIL reload_enter_load got core_reset=%0b count=%0d exp 1/0", core_reset_b, count_b); end
        ld_valid = 1'b1; ld_data = 32'hCAB1DAB1; ld_last = 1'b1;
        tick();
        tests_run++; if (we_b !== 1'b1 || addr_b !== 32'h0 || din_b !== 32'hCAB1DAB1) begin tests_failed++; $display("FAIL reload_write got we=%0b addr=%08h data=%08h exp 1/00000000/cab1dab1", we_b, addr_b, din_b); end
        idle_inputs();
        tick();
        tests_run++; if (core_reset_b !== 1'b0 || count_b !== 9'd1) begin tests_failed++; $display("FAIL reload_run got core_reset=%0b count=%0d exp 0/1", core_reset_b, count_b); end
        tests_run++; if (ram_b[0] !== 32'hCAB1DAB1 || ram_b[1] !== 32'hAAAA0002) begin tests_failed++; $display("FAIL reload_ram got %08h %08h exp cab1dab1 aaaa0002", ram_b[0], ram_b[1]); end
    endtask

    task automatic test_reset_midload();
        do_reset();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'h77770000;
        tick();
        ld_data = 32'h77770001;
        tick();
        ld_data = 32'h77770002;
        reset = 1'b1;
        tick();
        tests_run++; if (we_b !== 1'b0 || count_b !== 9'd0 || core_reset_b !== 1'b1 || addr_b !== 32'h0) begin tests_failed++; $display("FAIL midreset_state got we=%0b count=%0d core_reset=%0b addr=%08h exp 0/0/1/0", we_b, count_b, core_reset_b, addr_b); end
        reset = 1'b0;
        idle_inputs();
        tick();
        tests_run++; if (we_b !== 1'b0 || ld_ready_b !== 1'b0) begin tests_failed++; $display("FAIL midreset_after got we=%0b ready=%0b exp 0/0", we_b, ld_ready_b); end
        ld_start = 1'b1; run_req = 1'b1;
        tick();
        idle_inputs();
        #1;
        tests_run++; if (ld_ready_b !== 1'b1 || core_reset_b !== 1'b1) begin tests_failed++; $display("FAIL start_wins got ready=%0b core_reset=%0b exp 1/1", ld_ready_b, core_reset_b); end
        tick();
        tests_run++; if (core_reset_b !== 1'b1) begin tests_failed++; $display("FAIL start_wins_hold got core_reset=%0b exp 1", core_reset_b); end
    endtask

    task automatic test_run_req();
        do_reset();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        tests_run++; if (core_reset_b !== 1'b1 || we_b !== 1'b0) begin tests_failed++; $display("FAIL runreq_settle got core_reset=%0b we=%0b exp 1/0", core_reset_b, we_b); end
        tick();
        fetch_pc = 32'h0000_0044;
        #1;
        tests_run++; if (core_reset_b !== 1'b0 || addr_b !== 32'h0000_0044 || count_b !== 9'd0) begin tests_failed++; $display("FAIL runreq_run got core_reset=%0b addr=%08h count=%0d exp 0/00000044/0", core_reset_b, addr_b, count_b); end
        fetch_pc = 32'h0000_0F00;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        fetch_pc = 32'h0000_0F00;
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_full();
        test_reload();
        test_reset_midload();
        test_run_req();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
